// File: rtl/delay_sched_pkg.sv
// delay_sched_pkg: shared widths, depth and entry type for the delay scheduler.
//    DATA_W  sample width
//    DLY_W   per-sample delay field width
//    DEPTH   in-flight entries (power of two, >= 2)
//    PTR_W   circular-buffer pointer width
//    entry_t one buffered sample with its remaining hold time
package delay_sched_pkg;
   localparam int DATA_W = 4;
   localparam int DLY_W  = 4;
   localparam int DEPTH  = 4;
   localparam int PTR_W  = $clog2(DEPTH);
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [DLY_W-1:0]  remaining;
   } entry_t;
endpackage

// File: rtl/delay_sched_slot.sv
// delay_sched_slot: one buffer entry with load, saturating countdown, clear and zero flag.
//    clk, rst_n  clock and async active-low reset
//    flush_i     discard entry (highest priority)
//    load_i      write ent_i as a fresh entry (not decremented this edge)
//    pop_i       entry leaves the buffer
//    ent_i       entry to load
//    ent_o       stored entry
//    zero_o      remaining hold time has elapsed
module delay_sched_slot
   import delay_sched_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   flush_i,
   input  logic   load_i,
   input  logic   pop_i,
   input  entry_t ent_i,
   output entry_t ent_o,
   output logic   zero_o
);
   logic   occ_q, occ_d;
   entry_t ent_q, ent_d;
   always_comb begin
      occ_d = flush_i ? 1'b0 : load_i ? 1'b1 : pop_i ? 1'b0 : occ_q;
      ent_d = ent_q;
      if (occ_q && ent_q.remaining != '0) ent_d.remaining = ent_q.remaining - 1'b1;
      if (load_i) ent_d = ent_i;
      if (flush_i) ent_d = '0;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ_q <= 1'b0;
         ent_q <= '0;
      end else begin
         occ_q <= occ_d;
         ent_q <= ent_d;
      end
   end
   assign ent_o  = ent_q;
   assign zero_o = ent_q.remaining == '0;
endmodule

// File: rtl/delay_sched.sv
// delay_sched: in-order delay scheduler; each sample is held for its own delay, then released FIFO.
//    clk, rst_n           clock and async active-low reset
//    in_valid/in_ready    producer handshake; in_ready = !full, low until first edge after reset
//    in_data, in_delay    sample and its extra hold cycles
//    out_valid/out_ready  consumer handshake; head released once its delay elapsed
//    out_data             head sample, 0 when out_valid is low
//    flush                synchronous discard of everything (beats push and pop)
//    count, busy          occupancy and occupancy != 0
module delay_sched
   import delay_sched_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DLY_W-1:0]  in_delay,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [PTR_W:0]    count,
   output logic              busy
);
   logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             rdy_q, push, pop, empty, full;
   entry_t           ent [DEPTH];
   logic             zero [DEPTH];
   assign empty     = cnt_q == '0;
   assign full      = cnt_q == (PTR_W+1)'(DEPTH);
   // rdy_q holds in_ready low through reset and until the first edge after release
   assign in_ready  = rdy_q && !full;
   assign out_valid = !empty && zero[rd_q];
   assign out_data  = out_valid ? ent[rd_q].data : '0;
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;
   assign count     = cnt_q;
   assign busy      = !empty;
   always_comb begin
      wr_d  = flush ? '0 : wr_q + PTR_W'(push);
      rd_d  = flush ? '0 : rd_q + PTR_W'(pop);
      cnt_d = flush ? '0 : cnt_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         rdy_q <= 1'b0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         rdy_q <= 1'b1;
      end
   end
   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_slot
         delay_sched_slot u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .flush_i (flush),
            .load_i  (push && wr_q == PTR_W'(g)),
            .pop_i   (pop && rd_q == PTR_W'(g)),
            .ent_i   ('{data: in_data, remaining: in_delay}),
            .ent_o   (ent[g]),
            .zero_o  (zero[g])
         );
      end
   endgenerate
endmodule

// File: tb/tb_delay_sched.sv
// tb_delay_sched: directed self-checking bench for delay_sched.
module tb_delay_sched;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = '0;
   logic [3:0] in_delay = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic       flush = 1'b0;
   logic [2:0] count;
   logic       busy;
   int         n_cmp = 0;
   int         n_err = 0;

   delay_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_delay  (in_delay),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .count     (count),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d, input logic [3:0] dly);
      in_valid = 1'b1;
      in_data  = d;
      in_delay = dly;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_count", count, 0);
      check("rst_busy", busy, 0);
      step();
      rst_n = 1'b1;
      #2;
      check("rel_in_ready_low", in_ready, 0);
      step();
      check("rel_in_ready_high", in_ready, 1);

      // 1: single sample, delay 3
      out_ready = 1'b1;
      push(4'hA, 4'd3);
      check("t1_count", count, 1);
      for (int i = 1; i <= 3; i++) begin
         check("t1_hold", out_valid, 0);
         step();
      end
      check("t1_valid", out_valid, 1);
      check("t1_data", out_data, 4'hA);
      step();
      check("t1_gone", out_valid, 0);
      check("t1_count0", count, 0);

      // 2: head-of-line blocking
      push(4'h1, 4'd5);
      push(4'h2, 4'd0);
      check("t2_count", count, 2);
      for (int i = 2; i <= 5; i++) begin
         check("t2_blocked", out_valid, 0);
         step();
      end
      check("t2_first_valid", out_valid, 1);
      check("t2_first_data", out_data, 4'h1);
      step();
      check("t2_second_valid", out_valid, 1);
      check("t2_second_data", out_data, 4'h2);
      step();
      check("t2_empty", out_valid, 0);
      check("t2_count0", count, 0);

      // 3: full and backpressure
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(4'(i + 3), 4'd0);
      check("t3_count_full", count, 4);
      check("t3_in_ready_full", in_ready, 0);
      push(4'h7, 4'd0);
      check("t3_no_accept", count, 4);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_data", out_data, 4'h3);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t3_pop_data", out_data, 4'(i + 3));
         step();
         if (i == 0) check("t3_ready_back", in_ready, 1);
      end
      check("t3_count0", count, 0);
      check("t3_empty", out_valid, 0);

      // 4: simultaneous push/pop with pointer wrap
      out_ready = 1'b0;
      push(4'd0, 4'd0);
      push(4'd1, 4'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         in_data  = 4'(i + 2);
         in_delay = 4'd0;
         check("t4_valid", out_valid, 1);
         check("t4_data", out_data, i);
         step();
         check("t4_count", count, 2);
      end
      in_valid = 1'b0;
      step();
      step();
      check("t4_drained", count, 0);

      // 5: flush with concurrent push
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(4'(i + 8), 4'd0);
      check("t5_count3", count, 3);
      flush = 1'b1;
      push(4'hF, 4'd0);
      flush = 1'b0;
      check("t5_count0", count, 0);
      check("t5_out_valid", out_valid, 0);
      check("t5_busy", busy, 0);
      out_ready = 1'b1;
      step();
      step();
      check("t5_no_ghost", out_valid, 0);
      check("t5_still_empty", count, 0);

      // 6: async reset mid-countdown
      push(4'h5, 4'd9);
      step();
      check("t6_busy_before", busy, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_out_valid", out_valid, 0);
      check("t6_busy", busy, 0);
      check("t6_count", count, 0);
      check("t6_in_ready", in_ready, 0);
      step();
      #3;
      rst_n = 1'b1;
      #1;
      check("t6_in_ready_release", in_ready, 0);
      step();
      check("t6_in_ready_edge", in_ready, 1);
      check("t6_count_after", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
